// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle core (FETCH/EXEC/MEM plus I/O wait states) with a hardware
// return-address stack, valid/ready I/O ports and HALT/fault reporting.
module mc_cpu_core #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int DMEM_WORDS  = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [15:0]       i_imem_rdata,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_halted,
  output logic              o_fault
);
  localparam int SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int STK_AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int DM_AW  = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  localparam logic [3:0] OP_ADD  = 4'h1, OP_SUB = 4'h2, OP_NAND = 4'h3, OP_SHL = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5, OP_LDI = 4'h6, OP_IN   = 4'h7, OP_OUT = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9, OP_ST  = 4'hA, OP_BRZ  = 4'hB, OP_BRN = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD, OP_RET = 4'hE, OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_EXEC     = 3'd1,
    S_MEM      = 3'd2,
    S_IN_WAIT  = 3'd3,
    S_OUT_WAIT = 3'd4,
    S_STOP     = 3'd5
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_regs [4];
  logic              r_z;
  logic              r_n;
  logic [SP_W-1:0]   r_sp;
  logic [ADDR_W-1:0] r_stack [2**STK_AW];
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_halted;
  logic              r_fault;
  logic [DATA_W-1:0] r_dmem [2**DM_AW];
  logic [DATA_W-1:0] r_mem_rdata;

  logic [3:0]        w_op;
  logic [1:0]        w_rd;
  logic [1:0]        w_rs;
  logic [7:0]        w_imm;
  logic [DATA_W-1:0] w_imm_d;
  logic [ADDR_W-1:0] w_imm_a;
  logic [ADDR_W-1:0] w_pc_next;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_alu;
  logic              w_sp_full;
  logic              w_sp_empty;
  logic [STK_AW-1:0] w_push_idx;
  logic [STK_AW-1:0] w_pop_idx;
  logic [DM_AW-1:0]  w_dmem_idx;
  logic              w_mem_we;
  logic              w_mem_re;

  assign w_op       = r_ir[15:12];
  assign w_rd       = r_ir[11:10];
  assign w_rs       = r_ir[9:8];
  assign w_imm      = r_ir[7:0];
  assign w_imm_d    = DATA_W'(w_imm);
  assign w_imm_a    = ADDR_W'(w_imm);
  assign w_pc_next  = r_pc + ADDR_W'(2'd2);
  assign w_a        = r_regs[w_rd];
  assign w_b        = r_regs[w_rs];
  assign w_sp_full  = (r_sp == SP_W'(STACK_DEPTH));
  assign w_sp_empty = (r_sp == '0);
  assign w_push_idx = STK_AW'(r_sp);
  assign w_pop_idx  = STK_AW'(r_sp - SP_W'(1'b1));
  // imm addresses data memory modulo its size, so non-power-of-two depths stay in range
  assign w_dmem_idx = DM_AW'(32'(w_imm) % DMEM_WORDS);
  assign w_mem_we   = !i_rst && (r_state == S_EXEC) && (w_op == OP_ST);
  assign w_mem_re   = !i_rst && (r_state == S_EXEC) && (w_op == OP_LD);

  assign o_imem_addr = r_pc;
  assign o_in_ready  = r_in_ready;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_halted    = r_halted;
  assign o_fault     = r_fault;

  // ALU result for the arithmetic/logic opcodes; carry out is discarded.
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = w_a + w_b;
      OP_SUB:  w_alu = w_a - w_b;
      OP_NAND: w_alu = ~(w_a & w_b);
      OP_SHL:  w_alu = {w_a[DATA_W-2:0], 1'b0};
      OP_SHR:  w_alu = {1'b0, w_a[DATA_W-1:1]};
      default: w_alu = '0;
    endcase
  end

  // Data memory: written by ST, read into a register by LD; never cleared by reset.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_dmem[w_dmem_idx] <= w_a;
    if (w_mem_re) r_mem_rdata <= r_dmem[w_dmem_idx];
  end

  // Control FSM together with architectural state and registered port outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_ir        <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_sp        <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_halted    <= 1'b0;
      r_fault     <= 1'b0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      for (int i = 0; i < 2**STK_AW; i++) r_stack[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_ir    <= i_imem_rdata;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          case (w_op)
            OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR: begin
              r_regs[w_rd] <= w_alu;
              r_z          <= (w_alu == '0);
              r_n          <= w_alu[DATA_W-1];
              r_pc         <= w_pc_next;
            end
            OP_LDI: begin
              r_regs[w_rd] <= w_imm_d;
              r_pc         <= w_pc_next;
            end
            OP_IN: begin
              r_in_ready <= 1'b1;
              r_state    <= S_IN_WAIT;
            end
            OP_OUT: begin
              r_out_data  <= w_a;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT_WAIT;
            end
            OP_LD:  r_state <= S_MEM;
            OP_ST:  r_pc <= w_pc_next;
            OP_BRZ: r_pc <= r_z ? w_imm_a : w_pc_next;
            OP_BRN: r_pc <= r_n ? w_imm_a : w_pc_next;
            OP_CALL: begin
              if (w_sp_full) begin
                r_fault  <= 1'b1;
                r_halted <= 1'b1;
                r_state  <= S_STOP;
              end else begin
                r_stack[w_push_idx] <= w_pc_next;
                r_sp                <= r_sp + SP_W'(1'b1);
                r_pc                <= w_imm_a;
              end
            end
            OP_RET: begin
              if (w_sp_empty) begin
                r_fault  <= 1'b1;
                r_halted <= 1'b1;
                r_state  <= S_STOP;
              end else begin
                r_sp <= r_sp - SP_W'(1'b1);
                r_pc <= r_stack[w_pop_idx];
              end
            end
            OP_HALT: begin
              r_halted <= 1'b1;
              r_state  <= S_STOP;
            end
            default: r_pc <= w_pc_next;
          endcase
        end
        S_MEM: begin
          r_regs[w_rd] <= r_mem_rdata;
          r_pc         <= w_pc_next;
          r_state      <= S_FETCH;
        end
        S_IN_WAIT: begin
          if (i_in_valid && r_in_ready) begin
            r_regs[w_rd] <= i_in_data;
            r_pc         <= w_pc_next;
            r_in_ready   <= 1'b0;
            r_state      <= S_FETCH;
          end
        end
        S_OUT_WAIT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_pc        <= w_pc_next;
            r_state     <= S_FETCH;
          end
        end
        S_STOP:  r_state <= S_STOP;
        default: r_state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_cpu_core.sv
// Self-checking bench for mc_cpu_core: small programs in a bench-side instruction memory,
// output-port transfers scored against an expected queue, plus cycle-exact pc/port checks.
module tb_mc_cpu_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        halted;
  logic        fault;

  logic [15:0] imem [256];
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  int checks = 0;
  int failures = 0;

  mc_cpu_core #(.DATA_W(8), .ADDR_W(8), .STACK_DEPTH(4), .DMEM_WORDS(256)) dut (
    .i_clk(clk), .i_rst(rst), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
    .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_halted(halted), .o_fault(fault)
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem[imem_addr];

  // Capture output transfers; inputs only change 1ns after posedge, so negedge sees the handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) obs_q.push_back(out_data);
  end

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    exp_q.delete();
    obs_q.delete();
    rst = 1'b0;
  endtask

  task automatic run_until_halt(input int max);
    for (int i = 0; i < max && halted !== 1'b1; i++) tick(1);
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    clear_prog();
    do_reset();
    checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL reset_pc actual=%h required=00", imem_addr); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready actual=%b required=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid actual=%b required=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data actual=%h required=00", out_data); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted actual=%b required=0", halted); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault actual=%b required=0", fault); end
  endtask

  task automatic test_branch();
    logic [7:0] e, o;
    clear_prog();
    imem[8'h00] = ins(4'h6, 2'd0, 2'd0, 8'h05);
    imem[8'h02] = ins(4'h6, 2'd1, 2'd0, 8'h05);
    imem[8'h04] = ins(4'h2, 2'd0, 2'd1, 8'h00);
    imem[8'h06] = ins(4'hB, 2'd0, 2'd0, 8'h20);
    imem[8'h20] = ins(4'h8, 2'd0, 2'd0, 8'h00);
    imem[8'h22] = ins(4'hB, 2'd0, 2'd0, 8'h30);
    imem[8'h30] = ins(4'h6, 2'd1, 2'd0, 8'h77);
    imem[8'h32] = ins(4'h8, 2'd1, 2'd0, 8'h00);
    out_ready = 1'b1;
    do_reset();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h77);
    tick(7);
    checks++; if (imem_addr !== 8'h06) begin failures++; $display("FAIL branch_pc_c7 actual=%h required=06", imem_addr); end
    tick(1);
    checks++; if (imem_addr !== 8'h20) begin failures++; $display("FAIL branch_pc_c8 actual=%h required=20", imem_addr); end
    run_until_halt(100);
    checks++; if (halted !== 1'b1 || fault !== 1'b0) begin failures++; $display("FAIL branch_halt actual=%b%b required=10", halted, fault); end
    checks++; if (imem_addr !== 8'h34) begin failures++; $display("FAIL branch_halt_pc actual=%h required=34", imem_addr); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL branch_out_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL branch_out_data actual=%h required=%h", o, e); end
    end
  endtask

  task automatic test_alu_flags();
    logic [7:0] e, o;
    clear_prog();
    imem[8'h00] = ins(4'h6, 2'd2, 2'd0, 8'h80);
    imem[8'h02] = ins(4'h1, 2'd2, 2'd2, 8'h00);
    imem[8'h04] = ins(4'hB, 2'd0, 2'd0, 8'h10);
    imem[8'h10] = ins(4'hC, 2'd0, 2'd0, 8'h06);
    imem[8'h12] = ins(4'h8, 2'd2, 2'd0, 8'h00);
    imem[8'h14] = ins(4'h5, 2'd2, 2'd0, 8'h00);
    imem[8'h16] = ins(4'hB, 2'd0, 2'd0, 8'h20);
    imem[8'h20] = ins(4'h6, 2'd1, 2'd0, 8'h40);
    imem[8'h22] = ins(4'h4, 2'd1, 2'd0, 8'h00);
    imem[8'h24] = ins(4'hB, 2'd0, 2'd0, 8'h06);
    imem[8'h26] = ins(4'hC, 2'd0, 2'd0, 8'h30);
    imem[8'h30] = ins(4'h8, 2'd1, 2'd0, 8'h00);
    imem[8'h32] = ins(4'h3, 2'd1, 2'd1, 8'h00);
    imem[8'h34] = ins(4'h8, 2'd1, 2'd0, 8'h00);
    out_ready = 1'b1;
    do_reset();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h7F);
    run_until_halt(200);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL alu_halt actual=%b required=1", halted); end
    checks++; if (imem_addr !== 8'h36) begin failures++; $display("FAIL alu_halt_pc actual=%h required=36", imem_addr); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL alu_out_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL alu_out_data actual=%h required=%h", o, e); end
    end
  endtask

  task automatic test_in_out_stall();
    logic [7:0] e, o;
    clear_prog();
    imem[8'h00] = ins(4'h7, 2'd3, 2'd0, 8'h00);
    imem[8'h02] = ins(4'h8, 2'd3, 2'd0, 8'h00);
    in_valid = 1'b0; out_ready = 1'b0;
    do_reset();
    exp_q.push_back(8'hA5);
    tick(2);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b1 || imem_addr !== 8'h00) begin failures++; $display("FAIL in_stall actual=%b/%h required=1/00", in_ready, imem_addr); end
      tick(1);
    end
    in_data = 8'hA5; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0; in_data = 8'h00;
    checks++; if (in_ready !== 1'b0 || imem_addr !== 8'h02) begin failures++; $display("FAIL in_accept actual=%b/%h required=0/02", in_ready, imem_addr); end
    tick(2);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5) begin failures++; $display("FAIL out_hold actual=%b/%h required=1/a5", out_valid, out_data); end
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 8'h04) begin failures++; $display("FAIL out_done actual=%b/%h required=0/04", out_valid, imem_addr); end
    tick(3);
    checks++; if (halted !== 1'b1 || out_data !== 8'hA5) begin failures++; $display("FAIL out_retain actual=%b/%h required=1/a5", halted, out_data); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL io_out_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL io_out_data actual=%h required=%h", o, e); end
    end
  endtask

  task automatic test_call_overflow();
    clear_prog();
    for (int i = 0; i < 5; i++) imem[8'(2 * i)] = ins(4'hD, 2'd0, 2'd0, 8'(2 * i + 2));
    out_ready = 1'b0;
    do_reset();
    tick(8);
    checks++; if (imem_addr !== 8'h08 || halted !== 1'b0) begin failures++; $display("FAIL call_four actual=%h/%b required=08/0", imem_addr, halted); end
    tick(2);
    checks++; if (fault !== 1'b1 || halted !== 1'b1) begin failures++; $display("FAIL call_overflow actual=%b%b required=11", fault, halted); end
    checks++; if (imem_addr !== 8'h08) begin failures++; $display("FAIL call_overflow_pc actual=%h required=08", imem_addr); end
    tick(5);
    checks++; if (imem_addr !== 8'h08 || halted !== 1'b1) begin failures++; $display("FAIL call_frozen actual=%h/%b required=08/1", imem_addr, halted); end
  endtask

  task automatic test_call_ret();
    logic [7:0] e, o;
    clear_prog();
    imem[8'h00] = ins(4'h6, 2'd0, 2'd0, 8'h01);
    imem[8'h02] = ins(4'hD, 2'd0, 2'd0, 8'h20);
    imem[8'h04] = ins(4'h8, 2'd0, 2'd0, 8'h00);
    imem[8'h06] = ins(4'hE, 2'd0, 2'd0, 8'h00);
    imem[8'h20] = ins(4'h6, 2'd0, 2'd0, 8'h33);
    imem[8'h22] = ins(4'hD, 2'd0, 2'd0, 8'h40);
    imem[8'h24] = ins(4'h8, 2'd0, 2'd0, 8'h00);
    imem[8'h26] = ins(4'h6, 2'd0, 2'd0, 8'h55);
    imem[8'h28] = ins(4'hE, 2'd0, 2'd0, 8'h00);
    imem[8'h40] = ins(4'h6, 2'd0, 2'd0, 8'h44);
    imem[8'h42] = ins(4'hE, 2'd0, 2'd0, 8'h00);
    out_ready = 1'b1;
    do_reset();
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    run_until_halt(200);
    checks++; if (fault !== 1'b1 || halted !== 1'b1) begin failures++; $display("FAIL ret_underflow actual=%b%b required=11", fault, halted); end
    checks++; if (imem_addr !== 8'h06) begin failures++; $display("FAIL ret_underflow_pc actual=%h required=06", imem_addr); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL ret_out_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL ret_out_data actual=%h required=%h", o, e); end
    end
  endtask

  task automatic test_mem();
    logic [7:0] e, o;
    clear_prog();
    imem[8'h00] = ins(4'h6, 2'd1, 2'd0, 8'h3C);
    imem[8'h02] = ins(4'hA, 2'd1, 2'd0, 8'h10);
    imem[8'h04] = ins(4'h6, 2'd0, 2'd0, 8'hC3);
    imem[8'h06] = ins(4'hA, 2'd0, 2'd0, 8'h11);
    imem[8'h08] = ins(4'h9, 2'd2, 2'd0, 8'h10);
    imem[8'h0A] = ins(4'h8, 2'd2, 2'd0, 8'h00);
    imem[8'h0C] = ins(4'h9, 2'd3, 2'd0, 8'h11);
    imem[8'h0E] = ins(4'h8, 2'd3, 2'd0, 8'h00);
    out_ready = 1'b1;
    do_reset();
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    tick(10);
    checks++; if (imem_addr !== 8'h08) begin failures++; $display("FAIL ld_cycle2_pc actual=%h required=08", imem_addr); end
    tick(1);
    checks++; if (imem_addr !== 8'h0A) begin failures++; $display("FAIL ld_cycle3_pc actual=%h required=0a", imem_addr); end
    run_until_halt(100);
    checks++; if (halted !== 1'b1 || imem_addr !== 8'h10) begin failures++; $display("FAIL mem_halt actual=%b/%h required=1/10", halted, imem_addr); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL mem_out_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL mem_out_data actual=%h required=%h", o, e); end
    end
  endtask

  task automatic test_reset_mid_handshake();
    clear_prog();
    imem[8'h00] = ins(4'h6, 2'd0, 2'd0, 8'h5A);
    imem[8'h02] = ins(4'h8, 2'd0, 2'd0, 8'h00);
    out_ready = 1'b0; in_valid = 1'b0;
    do_reset();
    tick(4);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin failures++; $display("FAIL rst_pre_out actual=%b/%h required=1/5a", out_valid, out_data); end
    rst = 1'b1;
    tick(1);
    checks++; if (out_valid !== 1'b0 || imem_addr !== 8'h00 || out_data !== 8'h00) begin failures++; $display("FAIL rst_out_wait actual=%b/%h/%h required=0/00/00", out_valid, imem_addr, out_data); end
    imem[8'h00] = ins(4'h7, 2'd0, 2'd0, 8'h00);
    rst = 1'b0;
    tick(2);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_pre_in actual=%b required=1", in_ready); end
    rst = 1'b1;
    tick(1);
    checks++; if (in_ready !== 1'b0 || imem_addr !== 8'h00) begin failures++; $display("FAIL rst_in_wait actual=%b/%h required=0/00", in_ready, imem_addr); end
    rst = 1'b0;
    checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL rst_no_transfer actual=%0d required=0", obs_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, o;
    clear_prog();
    imem[8'h00] = ins(4'h7, 2'd0, 2'd0, 8'h00);
    imem[8'h02] = ins(4'h8, 2'd0, 2'd0, 8'h00);
    imem[8'h04] = ins(4'h2, 2'd0, 2'd0, 8'h00);
    imem[8'h06] = ins(4'h8, 2'd0, 2'd0, 8'h00);
    imem[8'h08] = ins(4'h3, 2'd0, 2'd0, 8'h00);
    imem[8'h0A] = ins(4'h8, 2'd0, 2'd0, 8'h00);
    in_data = 8'h21; in_valid = 1'b1; out_ready = 1'b1;
    do_reset();
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    tick(16);
    checks++; if (imem_addr !== 8'h0C || halted !== 1'b0) begin failures++; $display("FAIL b2b_pc actual=%h/%b required=0c/0", imem_addr, halted); end
    run_until_halt(20);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL b2b_halt actual=%b required=1", halted); end
    in_valid = 1'b0;
    checks++;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_out_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL b2b_out_data actual=%h required=%h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_alu_flags();
    test_in_out_stall();
    test_call_overflow();
    test_call_ret();
    test_mem();
    test_reset_mid_handshake();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_cpu_core.md
Name: mc_cpu_core

Overview:
- Parametrised multi-cycle successor to the single-cycle 8-bit core.
- Datapath width, program-counter width and call depth are generalised; the single link register becomes a hardware call stack.
- IN/OUT ports gain valid/ready handshakes, and the core adds HALT and fault reporting.
- Instruction memory stays external with a combinational read. Data memory is internal.

Parameters:
DATA_W, 8, register/ALU/port/data-memory word width (≥4)
ADDR_W, 8, PC and instruction address width
STACK_DEPTH, 4, return-address stack entries (≥1)
DMEM_WORDS, 256, internal data memory words, addressed by imm[7:0] modulo DMEM_WORDS

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
imem_addr  out  ADDR_W  instruction address (= pc)
imem_rdata  in  16  instruction word, combinational from imem_addr
in_data  in  DATA_W  input port data
in_valid  in  1  input data valid
in_ready  out  1  core accepting input
out_data  out  DATA_W  output port data
out_valid  out  1  output data valid
out_ready  in  1  consumer accepts output
halted  out  1  core stopped (HALT or fault)
fault  out  1  stack overflow/underflow occurred

Behaviour:
- Reset values (synchronous, active-high):
  - pc, all 4 registers, Z, N, stack pointer sp: 0
  - State FETCH
  - in_ready, out_valid, halted, fault: 0; out_data: 0
  - Data memory is not cleared.
- Instruction fields: op=[15:12], rd=[11:10], rs=[9:8], imm=[7:0]. imm is zero-extended or truncated to DATA_W (or ADDR_W for branch targets).
- Opcodes:
  - 0 NOP
  - 1 ADD: rd=rd+rs
  - 2 SUB: rd=rd−rs
  - 3 NAND
  - 4 SHL: rd<<1
  - 5 SHR: rd>>1 (logical)
  - 6 LDI: rd=imm
  - 7 IN: rd=in_data
  - 8 OUT: out_data=rd
  - 9 LD: rd=dmem[imm]
  - A ST: dmem[imm]=rd
  - B BRZ imm
  - C BRN imm
  - D CALL imm
  - E RET
  - F HALT
- Arithmetic: modulo 2^DATA_W, carry discarded.
- Flags:
  - Only ops 1–5 update Z and N. Z = (result==0); N = result[DATA_W−1].
  - Flags are registered and visible to the next instruction.
- PC:
  - Default next pc = pc+2, modulo 2^ADDR_W; pc wraps from max to 0.
  - A taken branch or CALL loads imm.
- States:
  - FETCH (1 cycle): latch imem_rdata into IR → EXEC.
  - EXEC (1 cycle): ALU/LDI/ST/NOP/branch complete → FETCH. LD → MEM. IN → IN_WAIT. OUT → OUT_WAIT. HALT → STOP.
  - MEM (1 cycle): registered dmem read written to rd; pc+=2 → FETCH. LD therefore takes 3 cycles; all other non-I/O ops take 2.
  - IN_WAIT:
    - in_ready=1.
    - On in_valid&in_ready: rd=in_data, pc+=2, in_ready drops next cycle → FETCH.
    - Stalls indefinitely otherwise.
  - OUT_WAIT:
    - On entry, out_data=rd and out_valid=1.
    - Both are held stable until out_ready; on out_valid&out_ready: out_valid=0, pc+=2 → FETCH.
    - out_data retains its last value afterwards.
  - STOP: halted=1. No further register, memory or pc changes. Exit only via rst.
- Call stack:
  - CALL pushes pc+2 at stack[sp], sp++, pc=imm.
  - RET: sp−−, pc=stack[sp−1].
  - CALL with sp==STACK_DEPTH is an overflow. RET with sp==0 is an underflow. Either sets fault=1 and halted=1 and goes to STOP; pc and sp are left unchanged.
- Branches: BRZ/BRN use the registered Z/N. Not-taken branches advance pc by 2.
- rd==rs is legal, e.g. SUB r1,r1 → 0, Z=1.
- rst asserted in any state, including IN_WAIT or OUT_WAIT mid-handshake, returns the core to reset values on the next edge; out_valid drops immediately.

Test Plan:
- LDI r0,5; LDI r1,5; SUB r0,r1; BRZ 0x20 → r0=0, Z=1, pc=0x20; the sequence takes 8 cycles.
- LDI r2,0x80; ADD r2,r2 (DATA_W=8) → r2=0x00, Z=1, N=0 (carry discarded). A following SHR leaves Z=1.
- IN r3 with in_valid low for 5 cycles, then in_data=0xA5 valid → in_ready high throughout the stall, r3=0xA5, pc advances once.
- OUT r3 with out_ready low for 4 cycles → out_valid=1 and out_data=0xA5 held stable; single transfer; out_valid=0 the cycle after the handshake.
- CALL ×5 with STACK_DEPTH=4 → first four push 0x02,0x04,…; fifth sets fault=1, halted=1, pc frozen. Separately, RET at sp=0 → fault=1.
- ST r1 @0x10; LD r2 @0x10; OUT r2 → out_data equals r1; LD measured at 3 cycles. rst asserted during OUT_WAIT → out_valid=0 and pc=0 next cycle.
